// File: rtl/implication_queue_pkg.sv
// Shared sizing constants for the BCP implication queue.
//   MAX_VARS_BITS  : width of a variable index
//   VAR_PER_CLAUSE : literals per clause seen by the unit-clause evaluator
//   IMPL_Q_DEPTH   : default number of pending-implication entries
package implication_queue_pkg;

  localparam int unsigned MAX_VARS_BITS  = 8;
  localparam int unsigned VAR_PER_CLAUSE = 3;
  localparam int unsigned IMPL_Q_DEPTH   = 8;

endpackage

// File: rtl/impl_match_cam.sv
// Combinational match of an incoming implication against all pending entries.
//   valid_mask   : which entries hold a pending implication
//   entry_vars   : packed entry variables, entry i at [i*VAR_BITS +: VAR_BITS]
//   entry_vals   : entry values
//   in_var/in_val: incoming implication
//   hit_same     : some valid entry has the same variable and value
//   hit_opposite : some valid entry has the same variable, opposite value
module impl_match_cam #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned VAR_BITS = 8
) (
  input  logic [DEPTH-1:0]          valid_mask,
  input  logic [DEPTH*VAR_BITS-1:0] entry_vars,
  input  logic [DEPTH-1:0]          entry_vals,
  input  logic [VAR_BITS-1:0]       in_var,
  input  logic                      in_val,
  output logic                      hit_same,
  output logic                      hit_opposite
);

  always_comb begin
    hit_same     = 1'b0;
    hit_opposite = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_mask[i] && (entry_vars[i*VAR_BITS +: VAR_BITS] == in_var)) begin
        if (entry_vals[i] == in_val) begin
          hit_same = 1'b1;
        end else begin
          hit_opposite = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/implication_queue.sv
// FIFO of pending implications between the unit-clause evaluator and the trail.
// Duplicates of pending implications are absorbed; an opposite-polarity
// implication of a pending variable raises a sticky conflict that freezes the
// queue until flush.
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   flush            : synchronous clear on backtrack (beats push and pop)
//   in_valid/in_var/in_val/in_ready     : implication input handshake
//   out_valid/out_var/out_val/out_ready : head-of-queue output handshake
//   conflict, conflict_var              : sticky conflict and its variable
//   count                                : number of pending entries
module implication_queue
  import implication_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = IMPL_Q_DEPTH,
  parameter int unsigned VAR_BITS = MAX_VARS_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [VAR_BITS-1:0]      in_var,
  input  logic                     in_val,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [VAR_BITS-1:0]      out_var,
  output logic                     out_val,
  input  logic                     out_ready,
  output logic                     conflict,
  output logic [VAR_BITS-1:0]      conflict_var,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][VAR_BITS-1:0] vars_q;
  logic [DEPTH-1:0]               vals_q;
  logic [DEPTH-1:0]               valid_q;
  logic [PTR_W-1:0]               head_q, tail_q;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           conflict_q;
  logic [VAR_BITS-1:0]            conflict_var_q;

  logic full, empty, push, pop, write;
  logic hit_same, hit_opposite;

  impl_match_cam #(
    .DEPTH    (DEPTH),
    .VAR_BITS (VAR_BITS)
  ) u_cam (
    .valid_mask   (valid_q),
    .entry_vars   (vars_q),
    .entry_vals   (vals_q),
    .in_var       (in_var),
    .in_val       (in_val),
    .hit_same     (hit_same),
    .hit_opposite (hit_opposite)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // in_ready ignores out_ready: no push into a full queue even when popping.
  // Gating with reset keeps the input closed while the queue is held in reset.
  assign in_ready  = !full && !conflict_q && !reset;
  assign out_valid = !empty && !conflict_q;

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  // The CAM still sees the head being popped, so a repeat of it is dropped.
  assign write = push && !hit_same && !hit_opposite;

  assign out_var      = vars_q[head_q];
  assign out_val      = vals_q[head_q];
  assign conflict     = conflict_q;
  assign conflict_var = conflict_var_q;
  assign count        = count_q;

  always_comb begin
    count_d = count_q;
    if (write && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!write && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vars_q         <= '0;
      vals_q         <= '0;
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
    end else if (flush) begin
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
    end else begin
      // write and pop never target the same slot: a write needs !full and a
      // pop needs !empty, so tail != head whenever both happen.
      if (write) begin
        vars_q[tail_q]  <= in_var;
        vals_q[tail_q]  <= in_val;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (push && hit_opposite) begin
        conflict_q     <= 1'b1;
        conflict_var_q <= in_var;
      end
    end
  end

endmodule

// File: tb/tb_implication_queue.sv
module tb_implication_queue;

  localparam int DEPTH = 8;
  localparam int VB    = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [VB-1:0] in_var;
  logic          in_val;
  logic          in_ready;
  logic          out_valid;
  logic [VB-1:0] out_var;
  logic          out_val;
  logic          out_ready;
  logic          conflict;
  logic [VB-1:0] conflict_var;
  logic [3:0]    count;

  implication_queue #(
    .DEPTH    (DEPTH),
    .VAR_BITS (VB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_var       (in_var),
    .in_val       (in_val),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_var      (out_var),
    .out_val      (out_val),
    .out_ready    (out_ready),
    .conflict     (conflict),
    .conflict_var (conflict_var),
    .count        (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [VB-1:0] v;
    logic          b;
  } impl_t;

  // Reference model: pending implications in FIFO order plus conflict state.
  impl_t         mq[$];
  logic          m_conf;
  logic [VB-1:0] m_cvar;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic m_ov;
    m_ov = (mq.size() > 0) && !m_conf;
    check("count", 32'(count), mq.size());
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("in_ready", 32'(in_ready), 32'((mq.size() < DEPTH) && !m_conf));
    check("conflict", 32'(conflict), 32'(m_conf));
    check("conflict_var", 32'(conflict_var), 32'(m_cvar));
    if (m_ov) begin
      check("out_var", 32'(out_var), 32'(mq[0].v));
      check("out_val", 32'(out_val), 32'(mq[0].b));
    end
  endtask

  // One clock cycle: check state-driven outputs, drive inputs, advance model.
  task automatic step(input logic iv, input int ivar, input logic ival,
                      input logic ordy, input logic fl);
    logic rdy, ov, do_push, do_pop;
    int   hit;
    impl_t e;
    @(negedge clock);
    check_outputs();
    in_valid  = iv;
    in_var    = VB'(ivar);
    in_val    = ival;
    out_ready = ordy;
    flush     = fl;
    rdy     = (mq.size() < DEPTH) && !m_conf;
    ov      = (mq.size() > 0) && !m_conf;
    do_push = iv && rdy;
    do_pop  = ov && ordy;
    hit     = 0;
    foreach (mq[i]) begin
      if (mq[i].v == VB'(ivar)) hit = (mq[i].b == ival) ? 1 : 2;
    end
    @(posedge clock);
    if (fl) begin
      mq.delete();
      m_conf = 1'b0;
      m_cvar = '0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (hit == 0) begin
          e.v = VB'(ivar);
          e.b = ival;
          mq.push_back(e);
        end else if (hit == 2) begin
          m_conf = 1'b1;
          m_cvar = VB'(ivar);
        end
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_var = '0; in_val = 1'b0;
    out_ready = 1'b0;
    m_conf = 1'b0; m_cvar = '0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_conflict", 32'(conflict), 0);
    check("rst_conflict_var", 32'(conflict_var), 0);
    check("rst_out_var", 32'(out_var), 0);
    check("rst_out_val", 32'(out_val), 0);
    @(negedge clock);
    reset = 1'b0;

    // Single push, one-cycle latency
    step(1'b1, 5, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Duplicate absorbed, FIFO order
    step(1'b1, 5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Conflict then flush
    step(1'b1, 5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 6, 1'b1, 1'b1, 1'b1);
    idle(1'b0);

    // Fill, then pop with a pending push; pointers wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, i[0], 1'b0, 1'b0);
    step(1'b1, 9, 1'b1, 1'b1, 1'b0);
    step(1'b1, 9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    idle(1'b0);

    // Push/pop at count=1: duplicate of head, then a new var
    step(1'b1, 3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) step(1'b1, 20 + i, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    check_outputs();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_count", 32'(count), 0);
    check("async_out_valid", 32'(out_valid), 0);
    check("async_in_ready", 32'(in_ready), 0);
    mq.delete();
    m_conf = 1'b0;
    m_cvar = '0;
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic over a small variable range to provoke hits
    for (int n = 0; n < 800; n++) begin
      logic fl;
      fl = m_conf ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11), 1'($urandom),
           $urandom_range(0, 1) == 1, fl);
    end

    @(negedge clock);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/implication_queue.md
# implication_queue

Sequential buffer directly downstream of `unit_clause_evaluator` in the BCP datapath. Accepts one implication per cycle (`is_unit_clause`, `implied_variable`, `new_val`), drops duplicates of already-pending implications, detects opposite-polarity implications of the same variable as a conflict, and releases implications in FIFO order to the assignment/trail stage over a valid/ready handshake. Cleared by `flush` on backtrack.

## Interface
- `DEPTH`, 8: number of pending-implication entries; power of two, ≥2.
- `VAR_BITS`, `` `MAX_VARS_BITS ``: width of a variable index.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `flush`  in  1  synchronous clear of entries and conflict (backtrack).
- `in_valid`  in  1  implication present (driven from `is_unit_clause`).
- `in_var`  in  VAR_BITS  implied variable (`implied_variable`).
- `in_val`  in  1  implied value (`new_val`).
- `in_ready`  out  1  queue accepts `in_*` this cycle.
- `out_valid`  out  1  head entry available.
- `out_var`  out  VAR_BITS  head variable.
- `out_val`  out  1  head value.
- `out_ready`  in  1  consumer takes head this cycle.
- `conflict`  out  1  sticky conflict flag.
- `conflict_var`  out  VAR_BITS  variable that caused the conflict.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- `in_ready = !full && !conflict`; it does not depend on `out_ready` (no push into a full queue, even with a same-cycle pop).
- On push, `in_var` is compared against every valid entry, including the head being popped that cycle:
  - match with the same value: duplicate. Accepted (handshake completes) but not written; `count` is unaffected by the push.
  - match with the opposite value: conflict. Not written; `conflict`←1 and `conflict_var`←`in_var` on the next edge.
  - no match: written at the tail.
- `out_valid = !empty && !conflict`. Once `conflict` is set, pops stop and entries are frozen until `flush`.
- `flush` has priority over push and pop: tail, head and count go to 0, `conflict` and `conflict_var` go to 0, and a same-cycle push is discarded.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.
- `count` is updated as count + push_written − pop.

## Timing
- Reset values: `count`=0, `out_valid`=0, `conflict`=0, `conflict_var`=0, `out_var`/`out_val`=0. `in_ready`=0 while `reset` is high.
- Latency: an entry pushed at edge N is visible on `out_*` after edge N (one cycle) when the queue was empty. There is no bypass path.
- A simultaneous push and pop when count=1 and the push is not a duplicate of the head: the head leaves, the new entry becomes head, and `count` stays 1.
- A push that duplicates the head while that head is being popped is still dropped; the implication was already delivered.
- A conflict detected at edge N: `out_valid` is low from N onward, including a pop attempted in the same cycle as the conflicting push. That pop is still honored, because `out_valid` was high before the edge.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of the handshake.

## Structure
- `` `MAX_VARS_BITS `` and `` `VAR_PER_CLAUSE `` remain in `sysdefs.svh`.
- Add `` `IMPL_Q_DEPTH `` there as the default for DEPTH.
- Natural sub-module: `impl_match_cam`. It takes the valid mask, entry vars and entry vals plus `in_var`/`in_val`, and returns `hit_same` and `hit_opposite`, both combinational.
- Storage is flop arrays; no SRAM.

## Test plan
- Reset, then push var=5 val=1 with `out_ready`=0 → `count`=1. After one cycle `out_valid`=1, `out_var`=5, `out_val`=1.
- Push var=5 val=1 twice, then var=7 val=0 → `count`=2. Pops return (5,1) then (7,0) and then `out_valid`=0.
- Pending (5,1), push (5,0) → next cycle `conflict`=1, `conflict_var`=5, `out_valid`=0, `in_ready`=0. Assert `flush` → `conflict`=0, `count`=0, `in_ready`=1.
- Fill DEPTH=8 distinct vars 0..7 → `in_ready`=0 and `count`=8. Pop one while `in_valid` is held with var 9 → 9 is accepted next cycle, pointers wrap, and the FIFO order is 1..7 then 9.
- With count=1 holding (3,0), push (3,0) while popping → head 3 is delivered once and `count`=0. Repeat with push (4,1) → `count`=1 and the head becomes 4.
- Assert `reset` asynchronously mid-stream with count=4 → `count`=0 and `out_valid`=0 before the next clock edge.
